// File: rtl/core_mdu_ctrl_pkg.sv
// Shared encodings for the RV32M multiply/divide controller.
package core_mdu_ctrl_pkg;

   localparam logic [6:0] MDU_OPCODE = 7'b0110011;
   localparam logic [6:0] MDU_FUNCT7 = 7'b0000001;

   localparam logic [2:0] F3_MUL    = 3'b000;
   localparam logic [2:0] F3_MULH   = 3'b001;
   localparam logic [2:0] F3_MULHSU = 3'b010;
   localparam logic [2:0] F3_MULHU  = 3'b011;
   localparam logic [2:0] F3_DIV    = 3'b100;
   localparam logic [2:0] F3_DIVU   = 3'b101;
   localparam logic [2:0] F3_REM    = 3'b110;
   localparam logic [2:0] F3_REMU   = 3'b111;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_RUN  = 2'd1,
      ST_DONE = 2'd2
   } mdu_state_e;

   // rs1 is read as signed for MULH, MULHSU, DIV and REM
   function automatic logic f3_signed1(input logic [2:0] f3);
      return (f3 == F3_MULH) || (f3 == F3_MULHSU) || (f3 == F3_DIV) || (f3 == F3_REM);
   endfunction

   function automatic logic f3_signed2(input logic [2:0] f3);
      return (f3 == F3_MULH) || (f3 == F3_DIV) || (f3 == F3_REM);
   endfunction

endpackage

// File: rtl/core_mdu_div_step.sv
// One combinational restoring-division step on unsigned magnitudes.
module core_mdu_div_step #(
   parameter int unsigned XLEN = 32
) (
   input  logic [XLEN-1:0] i_rem,
   input  logic [XLEN-1:0] i_quo,
   input  logic [XLEN-1:0] i_div,
   output logic [XLEN-1:0] o_rem_c,
   output logic [XLEN-1:0] o_quo_c
);

   logic [XLEN:0] w_shift;
   logic [XLEN:0] w_diff;

   assign w_shift = {i_rem, i_quo[XLEN-1]};
   assign w_diff  = w_shift - {1'b0, i_div};
   // a clear borrow means the divisor fits: keep the difference, shift in a 1
   assign o_rem_c = w_diff[XLEN] ? w_shift[XLEN-1:0] : w_diff[XLEN-1:0];
   assign o_quo_c = {i_quo[XLEN-2:0], ~w_diff[XLEN]};

endmodule

// File: rtl/core_mdu_ctrl.sv
// RV32M multiply/divide controller: 32-cycle iterative datapath with early-out cases.
// Optional single-cycle multiply when CORE_MDU_FAST_MUL_EN is defined.
module core_mdu_ctrl
   import core_mdu_ctrl_pkg::*;
#(
   parameter int unsigned XLEN = 32
) (
   input  logic            i_clk,
   input  logic            i_rstn,
   input  logic            i_valid,
   input  logic [2:0]      i_funct3,
   input  logic [XLEN-1:0] i_num1u,
   input  logic [XLEN-1:0] i_num2u,
   input  logic            i_kill,
   output logic            o_busy,
   output logic            o_valid,
   output logic [XLEN-1:0] o_res
);

   localparam int unsigned PW = 2 * XLEN;

   mdu_state_e      r_state, w_state_nxt;
   logic [4:0]      r_cnt;
   logic [XLEN-1:0] r_hi, r_lo, r_opb, r_res;
   logic [2:0]      r_funct3;
   logic            r_neg_q, r_neg_r, r_fin, r_valid, r_busy;

   logic            w_accept, w_fire, w_sgn1, w_sgn2, w_neg1, w_neg2;
   logic            w_div0, w_ovf, w_fast, w_skip;
   logic [XLEN-1:0] w_mag1, w_mag2, w_spec_res, w_load_hi, w_load_lo;
   logic [XLEN:0]   w_mul_sum;
   logic [XLEN-1:0] w_div_rem, w_div_quo, w_quo_s, w_rem_s, w_res;
   logic [PW-1:0]   w_prod, w_prod_s;

   assign w_accept = (r_state == ST_IDLE) && i_valid && !i_kill;
   assign w_fire   = (r_state == ST_DONE) && !i_kill;

   assign w_sgn1 = f3_signed1(i_funct3);
   assign w_sgn2 = f3_signed2(i_funct3);
   assign w_neg1 = w_sgn1 & i_num1u[XLEN-1];
   assign w_neg2 = w_sgn2 & i_num2u[XLEN-1];
   assign w_mag1 = w_neg1 ? (~i_num1u + XLEN'(1)) : i_num1u;
   assign w_mag2 = w_neg2 ? (~i_num2u + XLEN'(1)) : i_num2u;

   // divide-by-zero and signed overflow resolve at accept without iterating
   assign w_div0 = i_funct3[2] && (i_num2u == '0);
   assign w_ovf  = ((i_funct3 == F3_DIV) || (i_funct3 == F3_REM)) &&
                   (i_num1u == {1'b1, {(XLEN-1){1'b0}}}) && (&i_num2u);
   assign w_spec_res = w_div0 ? (i_funct3[1] ? i_num1u : '1)
                              : (i_funct3[1] ? '0 : i_num1u);

`ifdef CORE_MDU_FAST_MUL_EN
   logic signed [XLEN:0]   w_fa, w_fb;
   logic signed [PW+1:0]   w_fprod;
   assign w_fa    = {w_sgn1 & i_num1u[XLEN-1], i_num1u};
   assign w_fb    = {w_sgn2 & i_num2u[XLEN-1], i_num2u};
   assign w_fprod = w_fa * w_fb;
   assign w_fast  = !i_funct3[2];
`else
   assign w_fast  = 1'b0;
`endif

   assign w_skip = w_div0 | w_ovf | w_fast;

   always_comb begin
      w_load_hi = '0;
      w_load_lo = (w_div0 | w_ovf) ? w_spec_res : w_mag1;
`ifdef CORE_MDU_FAST_MUL_EN
      if (w_fast) begin
         w_load_hi = w_fprod[PW-1:XLEN];
         w_load_lo = w_fprod[XLEN-1:0];
      end
`endif
   end

   // shift-add multiply: {hi,lo} holds partial product above the unconsumed multiplier
   assign w_mul_sum = {1'b0, r_hi} + (r_lo[0] ? {1'b0, r_opb} : '0);

   core_mdu_div_step #(.XLEN(XLEN)) u_div_step (
      .i_rem   (r_hi),
      .i_quo   (r_lo),
      .i_div   (r_opb),
      .o_rem_c (w_div_rem),
      .o_quo_c (w_div_quo)
   );

   assign w_prod   = {r_hi, r_lo};
   assign w_prod_s = r_neg_q ? (~w_prod + PW'(1)) : w_prod;
   assign w_quo_s  = r_neg_q ? (~r_lo + XLEN'(1)) : r_lo;
   assign w_rem_s  = r_neg_r ? (~r_hi + XLEN'(1)) : r_hi;

   always_comb begin
      w_res = '0;
      if (r_fin)
         w_res = ((r_funct3 == F3_MUL) || r_funct3[2]) ? r_lo : r_hi;
      else if (r_funct3[2])
         w_res = r_funct3[1] ? w_rem_s : w_quo_s;
      else
         w_res = (r_funct3 == F3_MUL) ? w_prod_s[XLEN-1:0] : w_prod_s[PW-1:XLEN];
   end

   always_ff @(posedge i_clk or negedge i_rstn) begin
      if (!i_rstn) r_state <= ST_IDLE;
      else         r_state <= w_state_nxt;
   end

   always_comb begin
      w_state_nxt = r_state;
      unique case (r_state)
         ST_IDLE: if (w_accept) w_state_nxt = w_skip ? ST_DONE : ST_RUN;
         ST_RUN: begin
            if (i_kill)              w_state_nxt = ST_IDLE;
            else if (r_cnt == 5'd31) w_state_nxt = ST_DONE;
         end
         ST_DONE: w_state_nxt = ST_IDLE;
         default: w_state_nxt = ST_IDLE;
      endcase
   end

   always_ff @(posedge i_clk or negedge i_rstn) begin
      if (!i_rstn) begin
         r_cnt    <= '0;
         r_hi     <= '0;
         r_lo     <= '0;
         r_opb    <= '0;
         r_res    <= '0;
         r_funct3 <= '0;
         r_neg_q  <= 1'b0;
         r_neg_r  <= 1'b0;
         r_fin    <= 1'b0;
         r_valid  <= 1'b0;
         r_busy   <= 1'b0;
      end else begin
         r_busy  <= (w_state_nxt != ST_IDLE);
         r_valid <= w_fire;
         if (w_fire) r_res <= w_res;
         if (w_accept) begin
            r_funct3 <= i_funct3;
            r_hi     <= w_load_hi;
            r_lo     <= w_load_lo;
            r_opb    <= w_mag2;
            r_neg_q  <= w_neg1 ^ w_neg2;
            r_neg_r  <= w_neg1;
            r_fin    <= w_skip;
            r_cnt    <= '0;
         end else if (r_state == ST_RUN) begin
            r_cnt <= r_cnt + 5'd1;
            if (r_funct3[2]) begin
               r_hi <= w_div_rem;
               r_lo <= w_div_quo;
            end else begin
               r_hi <= w_mul_sum[XLEN:1];
               r_lo <= {w_mul_sum[0], r_lo[XLEN-1:1]};
            end
         end
      end
   end

   assign o_busy  = r_busy;
   assign o_valid = r_valid;
   assign o_res   = r_res;

endmodule

// File: tb/tb_core_mdu_ctrl.sv
// Self-checking bench for core_mdu_ctrl: transaction-level reference model plus directed literals.
module tb_core_mdu_ctrl;
   import core_mdu_ctrl_pkg::*;

`ifdef CORE_MDU_FAST_MUL_EN
   localparam int ML = 1;
`else
   localparam int ML = 33;
`endif

   logic        clk = 1'b0;
   logic        rstn, v, kill;
   logic [2:0]  f3;
   logic [31:0] a, b;
   logic        o_busy, o_valid;
   logic [31:0] o_res;

   int n_chk = 0;
   int n_pass = 0;

   always #5 clk = ~clk;

   core_mdu_ctrl #(.XLEN(32)) dut (
      .i_clk    (clk),
      .i_rstn   (rstn),
      .i_valid  (v),
      .i_funct3 (f3),
      .i_num1u  (a),
      .i_num2u  (b),
      .i_kill   (kill),
      .o_busy   (o_busy),
      .o_valid  (o_valid),
      .o_res    (o_res)
   );

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_chk++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got %08h expected %08h at %0t", nm, act, exp, $time);
   endtask

   // Architectural RV32M result from plain 64-bit arithmetic
   function automatic logic [31:0] ref_op(input logic [2:0] f, input logic [31:0] x, input logic [31:0] y);
      longint sx, sy, ux, uy;
      logic [63:0] p;
      sx = longint'($signed(x));
      sy = longint'($signed(y));
      ux = longint'({32'd0, x});
      uy = longint'({32'd0, y});
      p = '0;
      case (f)
         3'b000: p = ux * uy;
         3'b001: p = sx * sy;
         3'b010: p = sx * uy;
         3'b011: p = ux * uy;
         default: p = '0;
      endcase
      if (f == 3'b000) return p[31:0];
      if (!f[2]) return p[63:32];
      if (y == 32'd0) return f[1] ? x : 32'hFFFF_FFFF;
      if (f == 3'b100 && x == 32'h8000_0000 && y == 32'hFFFF_FFFF) return 32'h8000_0000;
      if (f == 3'b110 && x == 32'h8000_0000 && y == 32'hFFFF_FFFF) return 32'h0;
      case (f)
         3'b100:  p = sx / sy;
         3'b101:  p = ux / uy;
         3'b110:  p = sx % sy;
         default: p = ux % uy;
      endcase
      return p[31:0];
   endfunction

   // Edges from accept to the o_valid pulse
   function automatic int ltc(input logic [2:0] f, input logic [31:0] x, input logic [31:0] y);
      if (f[2] && (y == 32'd0 || ((f == 3'b100 || f == 3'b110) &&
                                   x == 32'h8000_0000 && y == 32'hFFFF_FFFF)))
         return 1;
      if (!f[2]) return ML;
      return 33;
   endfunction

   // Reference model and per-cycle compare
   logic        s_rst, s_v, s_k;
   logic [2:0]  s_f;
   logic [31:0] s_a, s_b;
   logic        m_pend = 1'b0;
   logic        m_valid = 1'b0;
   int          m_left = 0;
   logic [31:0] m_res = '0;
   logic [31:0] m_pres = '0;

   always @(posedge clk) begin
      s_rst = rstn; s_v = v; s_k = kill; s_f = f3; s_a = a; s_b = b;
      #1;
      if (!s_rst) begin
         m_pend = 1'b0; m_valid = 1'b0; m_left = 0; m_res = '0;
      end else begin
         m_valid = 1'b0;
         if (m_pend) begin
            if (s_k) m_pend = 1'b0;
            else begin
               m_left--;
               if (m_left == 0) begin
                  m_pend = 1'b0; m_valid = 1'b1; m_res = m_pres;
               end
            end
         end else if (s_v && !s_k) begin
            m_pend = 1'b1;
            m_left = ltc(s_f, s_a, s_b);
            m_pres = ref_op(s_f, s_a, s_b);
         end
      end
      chk("cyc_busy", 32'(o_busy), 32'(m_pend));
      chk("cyc_valid", 32'(o_valid), 32'(m_valid));
      chk("cyc_res", o_res, m_res);
   end

   task automatic tick();
      @(posedge clk);
      #2;
   endtask

   task automatic do_op(input logic [2:0] f, input logic [31:0] x, input logic [31:0] y,
                        input logic [31:0] exp, input bit use_exp, input int lat);
      int  n;
      bit  got;
      f3 = f; a = x; b = y; v = 1'b1;
      tick();
      v = 1'b0;
      n = 0; got = 1'b0;
      for (int k = 1; k <= 40 && !got; k++) begin
         tick();
         n = k;
         if (o_valid) got = 1'b1;
      end
      if (!got) chk("op_timeout", 32'd0, 32'd1);
      else begin
         chk("op_latency", 32'(n), 32'(lat));
         if (use_exp) chk("op_result", o_res, exp);
      end
   endtask

   initial begin
      int pulses;
      logic [2:0]  rf;
      logic [31:0] rx, ry;
      rstn = 1'b0; v = 1'b0; kill = 1'b0; f3 = '0; a = '0; b = '0;
      repeat (3) tick();
      chk("rst_busy", 32'(o_busy), 32'd0);
      chk("rst_valid", 32'(o_valid), 32'd0);
      chk("rst_res", o_res, 32'd0);
      rstn = 1'b1;
      repeat (2) tick();

      do_op(F3_MUL,    32'h0000_0007, 32'hFFFF_FFFD, 32'hFFFF_FFEB, 1, ML);
      do_op(F3_MULH,   32'h8000_0000, 32'h8000_0000, 32'h4000_0000, 1, ML);
      do_op(F3_MULHU,  32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 1, ML);
      do_op(F3_MULHSU, 32'hFFFF_FFFF, 32'h0000_0002, 32'hFFFF_FFFF, 1, ML);
      do_op(F3_DIV,    32'hFFFF_FFF9, 32'h0000_0002, 32'hFFFF_FFFD, 1, 33);
      do_op(F3_REM,    32'hFFFF_FFF9, 32'h0000_0002, 32'hFFFF_FFFF, 1, 33);
      do_op(F3_DIVU,   32'd100,       32'd7,         32'd14,        1, 33);
      do_op(F3_REMU,   32'd100,       32'd7,         32'd2,         1, 33);
      do_op(F3_DIVU,   32'd5,         32'd0,         32'hFFFF_FFFF, 1, 1);
      do_op(F3_REM,    32'd5,         32'd0,         32'd5,         1, 1);
      do_op(F3_DIV,    32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 1, 1);
      do_op(F3_REM,    32'h8000_0000, 32'hFFFF_FFFF, 32'h0000_0000, 1, 1);

      // kill while idle must block the accept
      v = 1'b1; kill = 1'b1; f3 = F3_DIVU; a = 32'd100; b = 32'd7;
      tick();
      chk("kill_idle_busy", 32'(o_busy), 32'd0);
      v = 1'b0; kill = 1'b0;
      tick();

      // kill at RUN cycle 10, new request in the same cycle is dropped
      f3 = F3_DIVU; a = 32'd1000; b = 32'd3; v = 1'b1;
      tick();
      v = 1'b0;
      repeat (10) tick();
      chk("run_busy", 32'(o_busy), 32'd1);
      kill = 1'b1; v = 1'b1; f3 = F3_DIVU; a = 32'd100; b = 32'd7;
      tick();
      chk("kill_busy", 32'(o_busy), 32'd0);
      chk("kill_valid", 32'(o_valid), 32'd0);
      kill = 1'b0;
      do_op(F3_DIVU, 32'd100, 32'd7, 32'd14, 1, 33);

      // async reset at RUN cycle 20
      f3 = F3_MUL; a = 32'd3; b = 32'd5; v = 1'b1;
      tick();
      v = 1'b0;
      repeat (20) tick();
      #1 rstn = 1'b0;
      #1;
      chk("arst_busy", 32'(o_busy), 32'd0);
      chk("arst_valid", 32'(o_valid), 32'd0);
      chk("arst_res", o_res, 32'd0);
      repeat (2) tick();
      rstn = 1'b1;
      pulses = 0;
      repeat (40) begin
         tick();
         if (o_valid) pulses++;
      end
      chk("post_rst_pulses", 32'(pulses), 32'd0);

      // held request: accepted, ignored while busy, then accepted again
      f3 = F3_DIVU; a = 32'd1000; b = 32'd7; v = 1'b1;
      pulses = 0;
      repeat (68) begin
         tick();
         if (o_valid) pulses++;
      end
      v = 1'b0;
      chk("held_pulses", 32'(pulses), 32'd2);
      chk("held_res", o_res, 32'd142);
      tick();

      for (int i = 0; i < 6; i++) begin
         rf = 3'($urandom_range(0, 7));
         rx = $urandom;
         ry = (i == 2) ? 32'hFFFF_FFFF : $urandom;
         do_op(rf, rx, ry, 32'd0, 0, ltc(rf, rx, ry));
      end
      repeat (3) tick();

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule

// File: doc/core_mdu_ctrl.md
CORE_MDU_CTRL -- requirements
Module: core_mdu_ctrl

Interface
REQ-001 SHALL have parameter XLEN, default 32: operand/result width; only 32 is supported.
REQ-002 SHALL have port i_clk, input, 1: single clock; all state updates on rising edge.
REQ-003 SHALL have port i_rstn, input, 1: reset, asynchronous, active-low.
REQ-004 SHALL have port i_valid, input, 1: request an RV32M operation this cycle.
REQ-005 SHALL have port i_funct3, input, 3: 000 MUL, 001 MULH, 010 MULHSU, 011 MULHU, 100 DIV, 101 DIVU, 110 REM, 111 REMU.
REQ-006 SHALL have ports i_num1u and i_num2u, input, XLEN: rs1 and rs2 operands, unsigned view.
REQ-007 SHALL have port i_kill, input, 1: pipeline flush; abort any operation in flight.
REQ-008 SHALL have port o_busy, input-side stall, output, 1: high whenever state is not IDLE.
REQ-009 SHALL have port o_valid, output, 1: one-cycle pulse, o_res valid.
REQ-010 SHALL have port o_res, output, XLEN: result.

Function
REQ-011 SHALL implement FSM states IDLE, RUN, DONE.
REQ-012 SHALL accept a request only when state is IDLE, i_valid=1, and i_kill=0; operands and funct3 are latched on the accepting edge.
REQ-013 SHALL ignore i_valid while o_busy=1; the requester holds the request until o_busy=0.
REQ-014 Transition IDLE->RUN SHALL occur on accept; a 5-bit counter clears to 0.
REQ-015 RUN SHALL perform one iteration per cycle (shift-add multiply or restoring divide on magnitudes) for exactly 32 cycles; at count 31 the next state SHALL be DONE.
REQ-016 DONE SHALL assert o_valid for exactly one cycle, then return to IDLE; o_valid therefore rises 33 cycles after the accepting edge.
REQ-017 The multiply SHALL form a 64-bit product: MUL returns bits [31:0]; MULH, MULHSU, and MULHU return bits [63:32], with operands signed×signed, signed×unsigned, and unsigned×unsigned respectively.
REQ-018 Signed operations SHALL negate magnitudes at the end: quotient sign = sign1 XOR sign2; remainder sign = sign of dividend.
REQ-019 Divide by zero SHALL skip RUN and go IDLE->DONE, so o_valid comes one cycle after accept. DIV and DIVU return 0xFFFFFFFF; REM and REMU return the dividend.
REQ-020 Signed overflow (0x80000000 / 0xFFFFFFFF) SHALL skip RUN in the same way. DIV returns 0x80000000; REM returns 0.
REQ-021 i_kill=1 in RUN or DONE SHALL force IDLE on the next edge with no o_valid pulse; i_kill in IDLE SHALL be a no-op.
REQ-022 o_res SHALL hold the last completed result until the next DONE.

Reset
REQ-023 While i_rstn=0: state=IDLE, counter=0, o_busy=0, o_valid=0, o_res=0, and all internal operand/accumulator registers=0.
REQ-024 Reset asserted mid-operation SHALL abandon the operation; no o_valid after release.

Configuration
REQ-025 When CORE_MDU_FAST_MUL_EN is defined, MUL, MULH, MULHSU, and MULHU SHALL use a single-cycle combinational 33×33 multiply: IDLE->DONE, o_valid one cycle after accept. Divides are unchanged.
REQ-026 When CORE_MDU_FAST_MUL_EN is undefined, all multiplies SHALL use the 32-cycle iterative path of REQ-015, and no hardware multiplier SHALL be inferred.

Structure
REQ-027 A shared package SHALL hold: funct3 encodings for the eight M operations, FSM state encoding, opcode 0110011, and funct7 0000001.
REQ-028 The iterative divider datapath SHALL be one sub-module, core_mdu_div_step: one restoring step, combinational, instantiated once. FSM, counter, sign handling, and multiply SHALL stay in core_mdu_ctrl.

Verification
REQ-029 MUL: 0x00000007 × 0xFFFFFFFD -> o_res=0xFFFFFFEB. o_valid at accept+33 (accept+1 with CORE_MDU_FAST_MUL_EN). o_busy high throughout.
REQ-030 MULH: 0x80000000 × 0x80000000 -> 0x40000000. MULHU: 0xFFFFFFFF × 0xFFFFFFFF -> 0xFFFFFFFE.
REQ-031 DIV: -7 / 2 -> 0xFFFFFFFD. REM: -7 / 2 -> 0xFFFFFFFF. DIVU: 100 / 7 -> 14. REMU: 100 / 7 -> 2.
REQ-032 DIVU 5 / 0 -> 0xFFFFFFFF; REM 5 / 0 -> 5; DIV 0x80000000 / 0xFFFFFFFF -> 0x80000000. Each gives o_valid at accept+1.
REQ-033 Accept DIVU, pulse i_kill at RUN cycle 10 -> IDLE next edge, no o_valid. A new request with i_valid=1 in the same cycle as i_kill is not accepted; the same request on the following cycle is accepted and completes correctly.
REQ-034 Deassert i_rstn at RUN cycle 20 -> all outputs 0 immediately. After release, no spurious o_valid; back-to-back requests each complete, and held i_valid is ignored while busy.
